// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory request/response bus between fetch unit and memory
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding-request fetch FSM with one-entry delivery buffer and branch redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      br_taken,
  input  logic [31:0]               br_target,
  input  logic                      stall,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               instr,
  output logic [31:0]               instr_pc,
  output logic                      instr_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DELIVER} state_t;
  state_t      state;
  logic [31:0] pc, pc_pending, tgt;
  assign tgt = {br_target[31:2], 2'b00};
  // the request address is the pc register itself, so it cannot move while a request is open
  assign imem.imem_addr = pc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      pc_pending    <= '0;
      imem.imem_req <= 1'b0;
      instr         <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state         <= FETCH;
          imem.imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_valid && br_taken) pc <= tgt;
          else if (imem.imem_valid) begin
            instr         <= imem.imem_rdata;
            instr_pc      <= pc;
            instr_valid   <= 1'b1;
            pc            <= pc + 32'(PC_STEP);
            imem.imem_req <= 1'b0;
            state         <= DELIVER;
          end else if (br_taken) begin
            pc_pending <= tgt;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          // a redirect arriving with the drained response is the latest one and wins
          if (imem.imem_valid) begin
            pc    <= br_taken ? tgt : pc_pending;
            state <= FETCH;
          end else if (br_taken) pc_pending <= tgt;
        end
        DELIVER: begin
          if (br_taken || !stall) begin
            instr_valid   <= 1'b0;
            imem.imem_req <= 1'b1;
            state         <= FETCH;
          end
          if (br_taken) pc <= tgt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, the byte increment between sequential fetches.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port br_taken  input  1  redirect request from branch control, sampled each cycle.
REQ-006 SHALL have port br_target  input  32  redirect byte address, valid when br_taken=1.
REQ-007 SHALL have port stall  input  1  downstream not accepting the presented instruction.
REQ-008 SHALL have port imem_req  output  1  instruction memory read request.
REQ-009 SHALL have port imem_addr  output  32  instruction memory byte address.
REQ-010 SHALL have port imem_rdata  input  32  memory read data, valid when imem_valid=1.
REQ-011 SHALL have port imem_valid  input  1  memory response strobe, one cycle per accepted request.
REQ-012 SHALL have port instr  output  32  fetched instruction word.
REQ-013 SHALL have port instr_pc  output  32  byte address of instr.
REQ-014 SHALL have port instr_valid  output  1  instr/instr_pc hold a deliverable instruction.

Function
REQ-015 SHALL implement states IDLE, FETCH, DRAIN, DELIVER; all outputs registered.
REQ-016 SHALL in IDLE drive imem_req=0 and move to FETCH on the next edge unconditionally.
REQ-017 SHALL in FETCH and DRAIN drive imem_req=1 with imem_addr=pc, holding the address stable until imem_valid=1.
REQ-018 SHALL in FETCH, on imem_valid=1 and br_taken=0: capture instr<=imem_rdata, instr_pc<=pc, set instr_valid, pc<=pc+PC_STEP, go to DELIVER.
REQ-019 SHALL in FETCH, on imem_valid=1 and br_taken=1: discard imem_rdata, pc<=br_target, remain in FETCH.
REQ-020 SHALL in FETCH, on imem_valid=0 and br_taken=1: pc_pending<=br_target, go to DRAIN (outstanding request is never abandoned).
REQ-021 SHALL in DRAIN discard the response; on imem_valid=1, pc<=pc_pending and go to FETCH; a further br_taken in DRAIN overwrites pc_pending (latest wins).
REQ-022 SHALL in DELIVER drive imem_req=0 and hold instr, instr_pc, instr_valid=1 while stall=1.
REQ-023 SHALL in DELIVER with stall=0 and br_taken=0 clear instr_valid and go to FETCH (one-entry buffer; throughput one instruction per 2+memory-latency cycles).
REQ-024 SHALL in DELIVER with br_taken=1 (regardless of stall) clear instr_valid, pc<=br_target, go to FETCH.
REQ-025 SHALL force bits [1:0] of every loaded br_target to 0.
REQ-026 SHALL compute pc+PC_STEP modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000, no flag).
REQ-027 SHALL ignore br_taken in IDLE and ignore imem_valid outside FETCH/DRAIN.
REQ-028 SHALL give br_taken priority over stall and over sequential increment in every state.

Reset
REQ-029 SHALL on rst=0, immediately and regardless of clk: state=IDLE, pc=RESET_PC, pc_pending=0, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
REQ-030 SHALL, on reset asserted mid-request, drop imem_req at once and discard any later imem_valid until FETCH is re-entered.
REQ-031 SHALL resume from IDLE on the first rising clk edge after rst returns to 1.

Verification
REQ-032 Sequential: 1-cycle memory returning addr-as-data, stall=0 -> instr_pc 0,4,8,... with instr==instr_pc, instr_valid pulses every 3rd cycle.
REQ-033 Stall: stall=1 for 5 cycles in DELIVER at instr_pc=8 -> instr/instr_pc constant, imem_req=0, no fetch of 12 until stall drops.
REQ-034 Branch while waiting: 4-cycle memory, br_taken=1 target 0x103 in cycle 1 of request at 0x10 -> 0x10 data discarded, next imem_addr=0x100, delivered instr_pc=0x100.
REQ-035 Branch with response: br_taken=1 target 0x40 same cycle as imem_valid for 0x20 -> no instr_valid for 0x20, next imem_addr=0x40.
REQ-036 Wrap: RESET_PC=32'hFFFF_FFFC -> delivered instr_pc FFFF_FFFC then 0000_0000.
REQ-037 Reset mid-op: rst=0 between edges while imem_req=1 -> imem_req, instr_valid low before next edge; after release first imem_addr=RESET_PC.
